// File: rtl/nmea_gga_tx_if.sv
// nmea_gga_tx_if: request/UART handshake bundle for the NMEA GGA sentence transmitter.
// Revision: 1.0
`default_nettype none

interface nmea_gga_tx_if;
   logic        start;
   logic [47:0] time_in;
   logic        TxD_busy;
   logic [7:0]  TxD_data_out;
   logic        TxD_start;
   logic        busy;
   logic        done;

   modport master (
      output start, time_in, TxD_busy,
      input  TxD_data_out, TxD_start, busy, done
   );

   modport slave (
      input  start, time_in, TxD_busy,
      output TxD_data_out, TxD_start, busy, done
   );
endinterface

`default_nettype wire

// File: rtl/nmea_gga_tx.sv
// nmea_gga_tx: emits "$GPGGA,<HHMMSS>,,...*CS\r\n" byte-by-byte to a UART; NMEA_CHECKSUM_EN adds "*CS".
// Revision: 1.0
`default_nettype none

module nmea_gga_tx #(
   parameter int NUM_EMPTY_FIELDS = 13
) (
   input  wire logic         CLK,
   input  wire logic         RST,
   nmea_gga_tx_if.slave      gga
);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SEND      = 3'd1,
      ST_WAIT_BUSY = 3'd2,
      ST_WAIT_FREE = 3'd3,
      ST_DONE      = 3'd4
   } state_t;

   localparam logic [5:0] c_IDX_STAR = 6'(13 + NUM_EMPTY_FIELDS);
`ifdef NMEA_CHECKSUM_EN
   localparam logic [5:0] c_IDX_LF   = 6'(13 + NUM_EMPTY_FIELDS + 4);
`else
   localparam logic [5:0] c_IDX_LF   = 6'(13 + NUM_EMPTY_FIELDS + 1);
`endif

   state_t      r_state;
   logic [5:0]  r_idx;
   logic [47:0] r_time;
   logic [7:0]  r_data;
   logic        r_txd_start;
   logic        r_busy;
   logic        r_done;
   logic [7:0]  w_byte;

`ifdef NMEA_CHECKSUM_EN
   logic [7:0]  r_csum;

   function automatic logic [7:0] f_hex(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction
`endif

   // Byte selected by index; trailing region resolves to '*', hex, CR or LF.
   always_comb begin
      w_byte = 8'h2C;
      case (r_idx)
         6'd0:  w_byte = 8'h24;
         6'd1:  w_byte = 8'h47;
         6'd2:  w_byte = 8'h50;
         6'd3:  w_byte = 8'h47;
         6'd4:  w_byte = 8'h47;
         6'd5:  w_byte = 8'h41;
         6'd6:  w_byte = 8'h2C;
         6'd7:  w_byte = r_time[47:40];
         6'd8:  w_byte = r_time[39:32];
         6'd9:  w_byte = r_time[31:24];
         6'd10: w_byte = r_time[23:16];
         6'd11: w_byte = r_time[15:8];
         6'd12: w_byte = r_time[7:0];
         default: begin
            if (r_idx < c_IDX_STAR)
               w_byte = 8'h2C;
`ifdef NMEA_CHECKSUM_EN
            else if (r_idx == c_IDX_STAR)
               w_byte = 8'h2A;
            else if (r_idx == c_IDX_STAR + 6'd1)
               w_byte = f_hex(r_csum[7:4]);
            else if (r_idx == c_IDX_STAR + 6'd2)
               w_byte = f_hex(r_csum[3:0]);
`endif
            else if (r_idx == c_IDX_LF)
               w_byte = 8'h0A;
            else
               w_byte = 8'h0D;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state     <= ST_IDLE;
         r_idx       <= 6'd0;
         r_time      <= 48'd0;
         r_data      <= 8'h00;
         r_txd_start <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
`ifdef NMEA_CHECKSUM_EN
         r_csum      <= 8'h00;
`endif
      end else begin
         r_txd_start <= 1'b0;
         r_done      <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (gga.start) begin
                  r_time  <= gga.time_in;
                  r_busy  <= 1'b1;
                  r_idx   <= 6'd0;
`ifdef NMEA_CHECKSUM_EN
                  r_csum  <= 8'h00;
`endif
                  r_state <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (!gga.TxD_busy) begin
                  r_data      <= w_byte;
                  r_txd_start <= 1'b1;
`ifdef NMEA_CHECKSUM_EN
                  // Only bytes strictly between '$' and '*' enter the checksum.
                  if (r_idx != 6'd0 && r_idx < c_IDX_STAR)
                     r_csum <= r_csum ^ w_byte;
`endif
                  r_state     <= ST_WAIT_BUSY;
               end
            end
            ST_WAIT_BUSY: begin
               if (gga.TxD_busy)
                  r_state <= ST_WAIT_FREE;
            end
            ST_WAIT_FREE: begin
               if (!gga.TxD_busy) begin
                  if (r_idx == c_IDX_LF) begin
                     r_done  <= 1'b1;
                     r_busy  <= 1'b0;
                     r_state <= ST_DONE;
                  end else begin
                     r_idx   <= r_idx + 6'd1;
                     r_state <= ST_SEND;
                  end
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign gga.TxD_data_out = r_data;
   assign gga.TxD_start    = r_txd_start;
   assign gga.busy         = r_busy;
   assign gga.done         = r_done;

endmodule

`default_nettype wire

// File: tb/tb_nmea_gga_tx.sv
// tb_nmea_gga_tx: directed bench with a UART model busy 10 cycles per byte.
// Revision: 1.0
`default_nettype none

module tb_nmea_gga_tx;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   nmea_gga_tx_if u_if ();

   nmea_gga_tx #(.NUM_EMPTY_FIELDS(13)) u_dut (
      .CLK (clk),
      .RST (rst),
      .gga (u_if)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   int          dones    = 0;
   int          viol     = 0;
   int          uart_cnt = 0;
   bit          hold     = 1'b0;
   logic [7:0]  q[$];

   localparam logic [47:0] c_T123519 = 48'h313233353139;
   localparam logic [47:0] c_T000000 = 48'h303030303030;
   localparam logic [47:0] c_T999999 = 48'h393939393939;

`ifdef NMEA_CHECKSUM_EN
   string s_123519 = "$GPGGA,123519,,,,,,,,,,,,,*5B";
   string s_000000 = "$GPGGA,000000,,,,,,,,,,,,,*56";
`else
   string s_123519 = "$GPGGA,123519,,,,,,,,,,,,,";
   string s_000000 = "$GPGGA,000000,,,,,,,,,,,,,";
`endif

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // UART model: loads on strobe, stays busy 10 cycles; hold forces busy high.
   always @(negedge clk) begin
      if (u_if.TxD_start) begin
         if (u_if.TxD_busy) viol++;
         q.push_back(u_if.TxD_data_out);
         uart_cnt = 10;
      end else if (uart_cnt > 0) begin
         uart_cnt--;
      end
      u_if.TxD_busy = (uart_cnt != 0) || hold;
      if (u_if.done) dones++;
   end

   task automatic pulse_start(input logic [47:0] t);
      @(negedge clk);
      u_if.time_in = t;
      u_if.start   = 1'b1;
      @(negedge clk);
      u_if.start   = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int base);
      int n = 0;
      while (dones == base && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_done_seen"}, 64'(dones != base), 64'd1);
      repeat (3) @(negedge clk);
   endtask

   task automatic check_sentence(input string tag, input string body);
      check({tag, "_len"}, 64'(q.size()), 64'(body.len() + 2));
      for (int i = 0; i < body.len(); i++) begin
         if (i < q.size())
            check($sformatf("%s_b%0d", tag, i), 64'(q[i]), 64'(body[i]));
      end
      if (q.size() == body.len() + 2) begin
         check({tag, "_cr"}, 64'(q[body.len()]),     64'h0D);
         check({tag, "_lf"}, 64'(q[body.len() + 1]), 64'h0A);
      end
   endtask

   initial begin
      int base;
      int n;
      u_if.start    = 1'b0;
      u_if.time_in  = 48'd0;
      u_if.TxD_busy = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_data",  64'(u_if.TxD_data_out), 64'h00);
      check("rst_start", 64'(u_if.TxD_start),    64'd0);
      check("rst_busy",  64'(u_if.busy),         64'd0);
      check("rst_done",  64'(u_if.done),         64'd0);
      rst = 1'b0;
      @(negedge clk);

      // Basic sentence with first-strobe latency check.
      q.delete();
      base = dones;
      pulse_start(c_T123519);
      check("busy_after_start", 64'(u_if.busy), 64'd1);
      @(negedge clk);
      check("first_strobe", 64'(u_if.TxD_start), 64'd1);
      check("first_byte",   64'(u_if.TxD_data_out), 64'h24);
      wait_done("s1", base);
      check_sentence("s1", s_123519);
      check("s1_one_done", 64'(dones - base), 64'd1);
      check("s1_busy_low", 64'(u_if.busy), 64'd0);

      // All-zero time changes only the checksum.
      q.delete();
      base = dones;
      pulse_start(c_T000000);
      wait_done("s0", base);
      check_sentence("s0", s_000000);

      // New time and start mid-sentence are ignored.
      q.delete();
      base = dones;
      pulse_start(c_T123519);
      n = 0;
      while (q.size() < 5 && n < 500) begin @(negedge clk); n++; end
      pulse_start(c_T999999);
      wait_done("dis", base);
      repeat (40) @(negedge clk);
      check_sentence("dis", s_123519);
      check("dis_one_done", 64'(dones - base), 64'd1);

      // UART busy when start arrives: no strobe until it falls.
      q.delete();
      base = dones;
      hold = 1'b1;
      @(negedge clk);
      pulse_start(c_T123519);
      repeat (20) @(negedge clk);
      check("hold_no_strobe", 64'(q.size()), 64'd0);
      check("hold_busy",      64'(u_if.busy), 64'd1);
      hold = 1'b0;
      wait_done("hold", base);
      check_sentence("hold", s_123519);

      // Reset after the 10th byte abandons the sentence.
      q.delete();
      base = dones;
      pulse_start(c_T123519);
      n = 0;
      while (q.size() < 10 && n < 500) begin @(negedge clk); n++; end
      check("rst_reached_10", 64'(q.size()), 64'd10);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_start", 64'(u_if.TxD_start), 64'd0);
      check("midrst_busy",  64'(u_if.busy),      64'd0);
      check("midrst_done",  64'(u_if.done),      64'd0);
      @(negedge clk);
      rst = 1'b0;
      n = 0;
      while (uart_cnt != 0 && n < 50) begin @(negedge clk); n++; end
      check("midrst_no_done", 64'(dones - base), 64'd0);
      q.delete();
      pulse_start(c_T123519);
      wait_done("post", base);
      check_sentence("post", s_123519);

      check("no_strobe_while_busy", 64'(viol), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/nmea_gga_tx.md
Name: nmea_gga_tx

Overview:
Builds an NMEA GGA sentence around a 48-bit ASCII UTC time (HHMMSS) and sends it one byte at a time to the UART transmitter. This is the transmit counterpart of the GGA time parser. It is used for loopback and self-test of the sprinkler controller's GPS path, and to drive a simulated GPS receiver. All non-time fields go out empty.

Parameters:
NUM_EMPTY_FIELDS, 13, number of ',' characters sent after the time field (legal range 0..15).

Ports:
CLK  input  1  system clock; all logic is on the rising edge
RST  input  1  synchronous, active-high reset
start  input  1  one-cycle request to send one sentence; ignored while busy=1
time_in  input  48  ASCII time; [47:40] is the first character (H tens) and [7:0] is the last (S units)
TxD_busy  input  1  UART transmitter busy, high while a byte is shifting out
TxD_data_out  output  8  byte presented to the UART
TxD_start  output  1  one-cycle strobe; the UART loads TxD_data_out on this cycle
busy  output  1  high while a sentence is in progress
done  output  1  one-cycle pulse after the final byte completes

Behaviour:
- Clock and reset: one clock (CLK); reset is synchronous and active-high (RST).
- Reset values: TxD_data_out=8'h00, TxD_start=0, busy=0, done=0, state=ST_IDLE, byte index=0, checksum=0. All outputs are registered.
- Byte sequence (31 bytes at default):
  - "$GPGGA,"
  - the 6 time chars
  - NUM_EMPTY_FIELDS x ','
  - '*', then checksum hi nibble, then checksum lo nibble
  - 8'h0D, 8'h0A
- Checksum:
  - 8-bit XOR of every byte strictly between '$' and '*'.
  - Accumulated as each byte is issued.
  - Cleared when a sentence starts.
- Hex encoding: each nibble maps 0-9 -> 8'h30-8'h39 and A-F -> 8'h41-8'h46 (uppercase).
- time_in is captured in the cycle start is accepted. Later changes to time_in do not affect the sentence in flight.
- Time characters are sent unmodified; no digit validation.
- States:
  - ST_IDLE: if start=1, capture time, set busy=1, clear the checksum and index, go to ST_SEND.
  - ST_SEND: if TxD_busy=0, drive TxD_data_out=byte[index] with TxD_start=1 for exactly one cycle, then go to ST_WAIT_BUSY. If TxD_busy=1, hold.
  - ST_WAIT_BUSY: wait for TxD_busy=1, then go to ST_WAIT_FREE. The UART raises busy within a cycle of TxD_start.
  - ST_WAIT_FREE: wait for TxD_busy=0. If the byte just sent was the last one (LF), go to ST_DONE; otherwise increment the index and go to ST_SEND.
  - ST_DONE: done=1 and busy=0 for one cycle, then go to ST_IDLE.
- Latency: the first TxD_start ('$') appears 2 cycles after start is sampled, assuming TxD_busy=0.
- A TxD_start is never issued while TxD_busy=1. Exactly one strobe is issued per byte.
- start while busy=1 (including during ST_DONE) is dropped, with no queueing. start in the cycle after the done pulse is accepted.
- RST mid-sentence: the next edge forces reset values, TxD_start drops immediately, and the partial sentence is abandoned with no done pulse.
- Width rules:
  - The byte index is 6 bits and covers up to 7+6+15+3+2=33 bytes.
  - The index never wraps within a sentence.

Optional Feature:
NMEA_CHECKSUM_EN:
- Defined: '*', hi hex and lo hex are sent before CR LF, as described above.
- Undefined: the checksum bytes are omitted. CR follows the last ',' directly, the sentence is 3 bytes shorter, and the checksum logic is not synthesized.

Test Plan:
- Default params, macro on, UART model busy for 10 cycles per byte, time_in="123519", start pulse -> 31 strobes carrying "$GPGGA,123519,,,,,,,,,,,,,*5B\r\n"; then a single done pulse; busy low afterwards.
- time_in="000000" -> checksum field "56", sentence otherwise identical.
- Macro off, time_in="123519" -> 28 bytes "$GPGGA,123519,,,,,,,,,,,,,\r\n"; no '*' sent.
- time_in changed and start re-pulsed mid-sentence -> both ignored; the sentence in flight still carries "123519"; exactly one done pulse.
- TxD_busy held high when start arrives -> no TxD_start until busy falls; then '$' is strobed; no strobe ever coincides with TxD_busy=1.
- RST asserted after the 10th byte -> TxD_start, busy and done are 0 on the next edge; a new start then produces a complete sentence beginning with '$'.
